// File: rtl/adder_nibble_serial_if.sv
// Purpose : Handshake and data bundle for adder_nibble_serial.
//           Upstream operand channel (valid_i/ready_o, a_i, b_i, carry_i) and
//           downstream result channel (valid_o/ready_i, sum_o, carry_o, overflow_o).
// Modports: slave  - the adder itself
//           master - the operand producer / result consumer
interface adder_nibble_serial_if #(
    parameter int WIDTH = 16
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             carry_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             overflow_o;

    modport slave (
        input  valid_i, a_i, b_i, carry_i, ready_i,
        output ready_o, valid_o, sum_o, carry_o, overflow_o
    );

    modport master (
        output valid_i, a_i, b_i, carry_i, ready_i,
        input  ready_o, valid_o, sum_o, carry_o, overflow_o
    );
endinterface

// File: rtl/adder_nibble_serial.sv
// Purpose : WIDTH-bit adder built from one 4-bit carry-lookahead slice that is
//           reused once per nibble, LSB nibble first, with the inter-nibble
//           carry held in a register. Reports sum, unsigned carry-out and
//           two's-complement overflow.
// Ports   : clk_i  - clock, rising edge
//           rst_ni - asynchronous active-low reset
//           bus    - adder_nibble_serial_if.slave (operand and result channels)
// WIDTH must match the interface instance parameter; multiple of 4, >= 4.
//
// state | meaning
// IDLE  | ready_o=1, waiting for operands
// RUN   | one nibble per cycle through the slice
// DONE  | valid_o=1, result held until ready_i
module adder_nibble_serial #(
    parameter int WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    adder_nibble_serial_if.slave   bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("adder_nibble_serial: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_a;
    logic             r_sign_b;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_p;
    logic [3:0]       w_g;
    logic [4:0]       w_c;
    logic [3:0]       w_sum4;

    assign w_accept = (r_state == IDLE) && bus.valid_i;
    assign w_last   = (r_cnt == CW'(NIB - 1));

    // 4-bit carry-lookahead slice: every carry is a flat sum of products of
    // generate/propagate terms and the carry register.
    assign w_p = r_a[3:0] ^ r_b[3:0];
    assign w_g = r_a[3:0] & r_b[3:0];

    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign w_sum4 = w_p ^ w_c[3:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.valid_i) w_state_next = RUN;
            RUN:     if (w_last)      w_state_next = DONE;
            DONE:    if (bus.ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.a_i;
            r_b      <= bus.b_i;
            r_carry  <= bus.carry_i;
            r_result <= '0;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            // New nibble enters at the top so the LSB nibble ends up at [3:0]
            // after NIB shifts.
            r_result <= WIDTH'({w_sum4, r_result} >> 4);
            r_carry  <= w_c[4];
            r_a      <= r_a >> 4;
            r_b      <= r_b >> 4;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                // On the final nibble the operand MSBs sit at bit 3.
                r_sign_a <= r_a[3];
                r_sign_b <= r_b[3];
            end
        end
    end

    assign bus.ready_o    = (r_state == IDLE);
    assign bus.valid_o    = (r_state == DONE);
    assign bus.sum_o      = r_result;
    assign bus.carry_o    = r_carry;
    assign bus.overflow_o = (r_sign_a == r_sign_b) && (r_result[WIDTH-1] != r_sign_a);

endmodule

// File: tb/tb_adder_nibble_serial.sv
module tb_adder_nibble_serial;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_c;
        logic         exp_ov;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    adder_nibble_serial_if #(.WIDTH(W)) bus ();

    adder_nibble_serial #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide addition, overflow from operand/result signs.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] s, output logic c, output logic ov);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        s    = full[W-1:0];
        c    = full[W];
        ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // One full transaction. 'hold' cycles of ready_i=0 in DONE; 'noise' keeps
    // valid_i high with changing operands while the adder is busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int hold, input bit noise,
                          output logic [W-1:0] s, output logic c, output logic ov);
        @(negedge clk);
        chk("ready_before_accept", bus.ready_o, 1);
        bus.valid_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.carry_i = cin;
        bus.ready_i = 1'b0;
        @(posedge clk);
        #1;
        bus.valid_i = noise;
        bus.a_i     = W'($urandom);
        bus.b_i     = W'($urandom);
        bus.carry_i = 1'($urandom);
        for (int k = 1; k <= NIB; k++) begin
            @(posedge clk);
            #1;
            if (noise) begin
                bus.a_i = W'($urandom);
                bus.b_i = W'($urandom);
            end
            chk("ready_while_busy", bus.ready_o, 0);
            chk("valid_latency", bus.valid_o, (k == NIB));
        end
        s  = bus.sum_o;
        c  = bus.carry_o;
        ov = bus.overflow_o;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", bus.valid_o, 1);
            chk("bp_sum", bus.sum_o, s);
            chk("bp_carry", bus.carry_o, c);
            chk("bp_ovf", bus.overflow_o, ov);
            chk("bp_ready", bus.ready_o, 0);
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("valid_after_hs", bus.valid_o, 0);
        chk("ready_after_hs", bus.ready_o, 1);
        chk("idle_keeps_sum", bus.sum_o, s);
    endtask

    vec_t vecs[7];

    initial begin
        logic [W-1:0] s, es, ra, rb;
        logic         c, ov, ec, eov, rc;
        bit           seen_valid;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        // Reset with random activity on the inputs.
        rst_n       = 1'b0;
        bus.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.valid_i = 1'($urandom);
            bus.a_i     = W'($urandom);
            bus.b_i     = W'($urandom);
            bus.carry_i = 1'($urandom);
            bus.ready_i = 1'($urandom);
            @(negedge clk);
            chk("rst_valid", bus.valid_o, 0);
            chk("rst_sum", bus.sum_o, 0);
            chk("rst_carry", bus.carry_o, 0);
            chk("rst_ovf", bus.overflow_o, 0);
            chk("rst_ready", bus.ready_o, 1);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", bus.ready_o, 1);
        chk("post_rst_valid", bus.valid_o, 0);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, s, c, ov);
            chk($sformatf("vec%0d_sum", i), s, vecs[i].exp_sum);
            chk($sformatf("vec%0d_carry", i), c, vecs[i].exp_c);
            chk($sformatf("vec%0d_ovf", i), ov, vecs[i].exp_ov);
        end

        // Backpressure for 5 cycles with operand noise during RUN/DONE.
        run_op(16'h1234, 16'h4321, 1'b0, 5, 1'b1, s, c, ov);
        chk("bp_seq_sum", s, 16'h5555);
        chk("bp_seq_carry", c, 0);
        chk("bp_seq_ovf", ov, 0);

        // Reset two RUN cycles into an operation.
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.a_i     = 16'h1111;
        bus.b_i     = 16'h2222;
        bus.carry_i = 1'b0;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.valid_o, 0);
        chk("midrst_ready", bus.ready_o, 1);
        chk("midrst_sum", bus.sum_o, 0);
        chk("midrst_carry", bus.carry_o, 0);
        chk("midrst_ovf", bus.overflow_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < NIB + 2; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) seen_valid = 1'b1;
        end
        chk("midrst_no_valid", seen_valid, 0);
        run_op(16'hAAAA, 16'h5555, 1'b0, 1, 1'b0, s, c, ov);
        chk("after_rst_sum", s, 16'hFFFF);
        chk("after_rst_carry", c, 0);
        chk("after_rst_ovf", ov, 0);

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (i % 8 == 0) rb = ~ra;
            model(ra, rb, rc, es, ec, eov);
            run_op(ra, rb, rc, int'($urandom_range(0, 2)), 1'($urandom), s, c, ov);
            chk("rand_sum", s, es);
            chk("rand_carry", c, ec);
            chk("rand_ovf", ov, eov);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_nibble_serial.md
# adder_nibble_serial

Multi-cycle WIDTH-bit adder that feeds a single internal 4-bit carry-lookahead slice one nibble per cycle, LSB nibble first, and carries between nibbles through a register. It sits between an operand producer (valid/ready upstream) and a result consumer (valid/ready downstream), trading latency for area where a full-width adder is not justified. It produces sum, carry-out and a signed-overflow flag.

## Interface
Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and ≥ 4 (elaboration error otherwise). NIB = WIDTH/4.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- valid_i  in  1  upstream operands valid.
- ready_o  out  1  block can accept operands.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- carry_i  in  1  carry-in for the whole add.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- sum_o  out  WIDTH  (a_i + b_i + carry_i) mod 2^WIDTH.
- carry_o  out  1  carry out of bit WIDTH-1.
- overflow_o  out  1  signed overflow: (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: ready_o=1, valid_o=0. On valid_i && ready_o: capture a_i, b_i into operand shift registers, carry_i into carry register; clear result register; nibble counter := 0; go to RUN.
- RUN: ready_o=0, valid_o=0. Each cycle the slice adds operand nibble [3:0] of A and B plus the carry register. On the clock edge: the 4-bit sum shifts into result[WIDTH-1:WIDTH-4] while result shifts right by 4; the slice carry-out loads the carry register; operands shift right by 4; counter increments. When counter == NIB-1, go to DONE. Before entering DONE, capture the sign bits of A and B for the overflow computation.
- DONE: valid_o=1, ready_o=0. sum_o, carry_o and overflow_o are stable. On ready_i: go to IDLE.
- sum_o is driven from the result register and carry_o from the carry register. overflow_o is computed from the captured sign bits and sum_o[WIDTH-1].
- Outputs are only meaningful while valid_o=1. During RUN, sum_o shows the partial shifted result, and the bench must not check it then.
- In IDLE after a completed transfer, sum_o, carry_o and overflow_o keep the last result until the next accept.
- valid_i is ignored outside IDLE, and the operands on a_i/b_i are not sampled then.
- Arithmetic is unsigned modulo 2^WIDTH. carry_o is the unsigned carry. overflow_o is the two's-complement overflow. Both flags are reported every time.

## Timing
- Reset (rst_ni=0, asynchronous): state=IDLE, valid_o=0, sum_o=0, carry_o=0, overflow_o=0, counter=0. ready_o=1 while in reset and immediately after reset is released.
- Latency: operands accepted on edge E; valid_o rises after edge E+NIB. Example: WIDTH=16 gives 4 RUN cycles. WIDTH=4 gives 1 RUN cycle.
- Minimum initiation interval: NIB+2 cycles (accept, NIB RUN cycles, at least 1 DONE cycle, then IDLE).
- Back-to-back accept in the cycle that DONE handshakes is not supported: IDLE always lasts at least one cycle.
- Backpressure: valid_o stays high and outputs stay unchanged for any number of cycles while ready_i=0.
- ready_i during IDLE or RUN has no effect.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No valid_o pulse follows. The next operation after reset is fully correct.
- No combinational path from inputs to outputs. ready_o and valid_o decode from state only.

## Test plan
- Reset: hold rst_ni=0 with random inputs → valid_o=0, sum_o=0, carry_o=0, overflow_o=0, ready_o=1. Release reset → state IDLE, ready_o=1.
- Basic, WIDTH=16: 0x1234 + 0x4321, carry_i=0 → after exactly 4 RUN cycles valid_o=1, sum_o=0x5555, carry_o=0, overflow_o=0. Also 0x000F + 0x0000, carry_i=1 → sum_o=0x0010.
- Full carry propagation: 0xFFFF + 0x0001 → sum_o=0x0000, carry_o=1, overflow_o=0. 0xFFFF + 0x0000, carry_i=1 → sum_o=0x0000, carry_o=1.
- Signed overflow: 0x7FFF + 0x0001 → sum_o=0x8000, carry_o=0, overflow_o=1. 0x8000 + 0x8000 → sum_o=0x0000, carry_o=1, overflow_o=1.
- Handshake: hold ready_i=0 for 5 cycles in DONE → outputs are constant and valid_o stays 1. Toggle valid_i with new operands during RUN/DONE → operands ignored, ready_o=0. After ready_i=1 → valid_o=0 next cycle, and the next operation starts only from IDLE.
- Reset mid-operation: accept 0x1111 + 0x2222, assert rst_ni=0 after 2 RUN cycles → immediate IDLE and all outputs 0, no valid_o. Then run 0xAAAA + 0x5555 → sum_o=0xFFFF, carry_o=0, overflow_o=0.
